// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit direction counters, per-set LRU and an INIT invalidate walk.
// Optional statistics counters enabled by defining BTB_STATS_EN.
module btb_assoc_way #(
  parameter int XLEN  = 32,
  parameter int SETS  = 256,
  parameter int IDX_W = 8,
  parameter int TAG_W = 22
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [XLEN-1:0]  lk_target,
  output logic [1:0]       lk_cnt,
  input  logic [IDX_W-1:0] up_idx,
  input  logic [TAG_W-1:0] up_tag,
  output logic             up_hit,
  output logic             up_vld,
  output logic [1:0]       up_cnt,
  input  logic             clr,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             we_alloc,
  input  logic             we_cnt,
  input  logic             we_tgt,
  input  logic [1:0]       wr_cnt,
  input  logic [XLEN-1:0]  wr_target
);
  logic             vld_q [SETS];
  logic [TAG_W-1:0] tag_q [SETS];
  logic [XLEN-1:0]  tgt_q [SETS];
  logic [1:0]       cnt_q [SETS];

  // Storage needs no reset: the INIT walk clears valid before any lookup can hit.
  always_ff @(posedge i_clk) begin
    if (clr) vld_q[clr_idx] <= 1'b0;
    else if (we_alloc) begin
      vld_q[up_idx] <= 1'b1;
      tag_q[up_idx] <= up_tag;
    end
    if (we_cnt) cnt_q[up_idx] <= wr_cnt;
    if (we_tgt) tgt_q[up_idx] <= wr_target;
  end

  assign lk_hit    = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_target = tgt_q[lk_idx];
  assign lk_cnt    = cnt_q[lk_idx];
  assign up_vld    = vld_q[up_idx];
  assign up_hit    = vld_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_cnt    = cnt_q[up_idx];
endmodule

module btb_assoc #(
  parameter int         XLEN     = 32,
  parameter int         SETS     = 256,
  parameter int         WAYS     = 2,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_four,
  output logic [XLEN-1:0] o_pc_predict,
  output logic            o_hit,
  output logic            o_taken,
  output logic [1:0]      o_cnt,
  output logic            o_ready,
`ifdef BTB_STATS_EN
  output logic [31:0]     o_stat_lookup,
  output logic [31:0]     o_stat_hit,
  output logic [31:0]     o_stat_mispred,
`endif
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SETS-1:0]  lru_q;
  logic             ready, upd_go;

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  logic [WAYS-1:0]             lk_hit, up_hit, up_vld, we_alloc, we_cnt, we_tgt;
  logic [WAYS-1:0][XLEN-1:0]   lk_tgt;
  logic [WAYS-1:0][1:0]        lk_cnt, up_cnt;
  logic [XLEN-1:0]  sel_tgt;
  logic [1:0]       sel_cnt, h_cnt, nxt_cnt, wr_cnt;
  logic             u_hit, h_way, victim, alloc;
  logic             unused_addr;

  assign unused_addr = ^{i_pc[1:0], i_upd_pc[1:0]};
  assign lk_idx = i_pc[IDX_W+1:2];
  assign lk_tag = i_pc[XLEN-1:IDX_W+2];
  assign u_idx  = i_upd_pc[IDX_W+1:2];
  assign u_tag  = i_upd_pc[XLEN-1:IDX_W+2];
  assign ready  = (state_q == ST_RUN);
  assign upd_go = ready & i_upd_valid & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (i_flush) begin
      state_d = ST_INIT;
      idx_d   = '0;
    end else if (state_q == ST_INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_W'(SETS - 1)) state_d = ST_RUN;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_assoc_way #(.XLEN(XLEN), .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way (
      .i_clk    (i_clk),
      .lk_idx   (lk_idx),
      .lk_tag   (lk_tag),
      .lk_hit   (lk_hit[w]),
      .lk_target(lk_tgt[w]),
      .lk_cnt   (lk_cnt[w]),
      .up_idx   (u_idx),
      .up_tag   (u_tag),
      .up_hit   (up_hit[w]),
      .up_vld   (up_vld[w]),
      .up_cnt   (up_cnt[w]),
      .clr      (state_q == ST_INIT),
      .clr_idx  (idx_q),
      .we_alloc (we_alloc[w]),
      .we_cnt   (we_cnt[w]),
      .we_tgt   (we_tgt[w]),
      .wr_cnt   (wr_cnt),
      .wr_target(i_upd_target)
    );
  end

  // Lookup: tags are unique within a set, so at most one way matches.
  always_comb begin
    sel_tgt = '0;
    sel_cnt = '0;
    for (int w = 0; w < WAYS; w++)
      if (lk_hit[w]) begin
        sel_tgt = lk_tgt[w];
        sel_cnt = lk_cnt[w];
      end
  end

  assign o_ready      = ready;
  assign o_hit        = ready & (|lk_hit);
  assign o_cnt        = o_hit ? sel_cnt : 2'b00;
  assign o_taken      = o_hit & sel_cnt[1];
  assign o_pc_predict = o_taken ? sel_tgt : i_pc_four;

  always_comb begin
    h_way = 1'b0;
    h_cnt = '0;
    for (int w = 0; w < WAYS; w++)
      if (up_hit[w]) begin
        h_way = 1'(w);
        h_cnt = up_cnt[w];
      end
    u_hit = |up_hit;
    if (WAYS == 1)             victim = 1'b0;
    else if (!up_vld[0])       victim = 1'b0;
    else if (!up_vld[WAYS-1])  victim = 1'b1;
    else                       victim = lru_q[u_idx];
    if (i_upd_taken) nxt_cnt = (h_cnt == 2'b11) ? h_cnt : h_cnt + 2'b01;
    else             nxt_cnt = (h_cnt == 2'b00) ? h_cnt : h_cnt - 2'b01;
    wr_cnt = u_hit ? nxt_cnt : CNT_INIT;
    alloc  = upd_go & ~u_hit & i_upd_taken;
    for (int w = 0; w < WAYS; w++) begin
      we_alloc[w] = alloc & (victim == 1'(w));
      we_cnt[w]   = we_alloc[w] | (upd_go & up_hit[w]);
      we_tgt[w]   = we_alloc[w] | (upd_go & up_hit[w] & i_upd_taken);
    end
  end

  // LRU bit names the way to evict next.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lru_q <= '0;
    else if (WAYS == 2 && upd_go && (u_hit || alloc))
      lru_q[u_idx] <= u_hit ? ~h_way : ~victim;
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_lookup  <= '0;
      o_stat_hit     <= '0;
      o_stat_mispred <= '0;
    end else begin
      if (ready) o_stat_lookup <= o_stat_lookup + 32'd1;
      if (o_hit) o_stat_hit    <= o_stat_hit + 32'd1;
      if (upd_go && ((u_hit ? h_cnt[1] : 1'b0) != i_upd_taken))
        o_stat_mispred <= o_stat_mispred + 32'd1;
    end
  end
`endif
endmodule
